nvm_sched: RTL



---
 rtl/nvm_sched_pkg.sv | 21 ++
 rtl/nvm_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/nvm_sched_pkg.sv
// Shared types and constants for the NVM phase sequencer / access scheduler.
package nvm_sched_pkg;

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_RUN  = 2'd1,
      S_PROG = 2'd2
   } sched_state_t;

   localparam logic [1:0] SLOT_PH0  = 2'd0;
   localparam logic [1:0] SLOT_PH1  = 2'd1;
   localparam logic [1:0] SLOT_PH2  = 2'd2;
   localparam logic [1:0] SLOT_STEP = 2'd3;

   localparam int FRAME_LEN = 4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/nvm_sched.sv
// Frame sequencer for the shared MRAM port (fetch / capture / data / step) and
// handover of that port to the SPI programmer with single-cycle write pulses.
module nvm_sched
   import nvm_sched_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int RST_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              prog_mode,
   input  logic              preq_valid,
   output logic              preq_ready,
   input  logic [ADDR_W-1:0] preq_addr,
   input  logic [DATA_W-1:0] preq_data,
   output logic              ph0,
   output logic              ph1,
   output logic              ph2,
   output logic              cpu_step,
   output logic              cpu_reset,
   output logic              pwe,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pdata,
   output logic [15:0]       prog_count
);

   localparam int HW = $clog2(RST_HOLD + 1);

   sched_state_t      state_q, state_d;
   logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
   logic [1:0]        slot_q, slot_d;
   logic              pwe_q, pwe_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pdata_q, pdata_d;
   logic [15:0]       prog_count_q, prog_count_d;
   logic              accept;

   // Ready is withheld during the pulse cycle, so writes are at most every other cycle.
   assign accept = (state_q == S_PROG) && !pwe_q && preq_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_HOLD;
         hold_cnt_q   <= HW'(RST_HOLD);
         slot_q       <= SLOT_PH0;
         pwe_q        <= 1'b0;
         paddr_q      <= '0;
         pdata_q      <= '0;
         prog_count_q <= '0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         slot_q       <= slot_d;
         pwe_q        <= pwe_d;
         paddr_q      <= paddr_d;
         pdata_q      <= pdata_d;
         prog_count_q <= prog_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HOLD: begin
            if (hold_cnt_q <= HW'(1))
               state_d = prog_mode ? S_PROG : S_RUN;
         end
         S_RUN: begin
            // Only the last slot may leave, so a frame always completes.
            if (slot_q == SLOT_STEP && prog_mode)
               state_d = S_PROG;
         end
         S_PROG: begin
            // A handshake taken as prog_mode falls keeps us here for its pulse.
            if (!prog_mode && !accept)
               state_d = S_HOLD;
         end
         default: state_d = S_HOLD;
      endcase
   end

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_q == S_HOLD && hold_cnt_q != '0)
         hold_cnt_d = hold_cnt_q - HW'(1);
      if (state_d == S_HOLD && state_q != S_HOLD)
         hold_cnt_d = HW'(RST_HOLD);

      slot_d = (state_q == S_RUN) ? slot_q + 2'd1 : SLOT_PH0;

      pwe_d   = accept;
      paddr_d = accept ? preq_addr : paddr_q;
      pdata_d = accept ? preq_data : pdata_q;

      prog_count_d = prog_count_q;
      if (state_d == S_PROG && state_q != S_PROG)
         prog_count_d = '0;
      else if (pwe_q)
         prog_count_d = sat_inc16(prog_count_q);
   end

   always_comb begin
      cpu_reset  = (state_q != S_RUN);
      ph0        = (state_q == S_RUN) && (slot_q == SLOT_PH0);
      ph1        = (state_q == S_RUN) && (slot_q == SLOT_PH1);
      ph2        = (state_q == S_RUN) && (slot_q == SLOT_PH2);
      cpu_step   = (state_q == S_RUN) && (slot_q == SLOT_STEP);
      preq_ready = (state_q == S_PROG) && !pwe_q;
      pwe        = pwe_q;
      paddr      = paddr_q;
      pdata      = pdata_q;
      prog_count = prog_count_q;
   end

endmodule
